decode_stage_hazard: RTL and testbench
======================================

// Module: decode_stage_hazard
// PURPOSE
// - Parametrised successor to the decode stage. Holds the register file and splits INSTRUCTIONWIDTH
//   instructions into fields. Drives the Decode->Execute pipeline register with a valid bit.
// - Adds load-use stall generation, branch flush, WB->D write-through bypass and E-stage forwarding selects.
// - Sits between the fetch stage (driven by stall_d) and execute (consumes *_e and fwd_sel*_e).
// PARAMETERS
// WIDTH            16  datapath / register width
// REGNUM           16  number of registers
// ADDRESSWIDTH     4   register address width, $clog2(REGNUM)
// OPCODEWIDTH      4   opcode field width
// IMMWIDTH         8   immediate field width, <= WIDTH
// INSTRUCTIONWIDTH 24  = OPCODEWIDTH + 3*ADDRESSWIDTH + IMMWIDTH
// CTRLWIDTH        8   opaque control bundle from the control unit, passed D->E
// PORTS
// clock          in   1            rising-edge clock
// reset          in   1            asynchronous, active-low reset
// instr_valid_d  in   1            instruction_d holds a real instruction
// instruction_d  in   INSTRUCTIONWIDTH  {opcode, rd, rs1, rs2, imm}, MSB first
// pc_d           in   WIDTH        PC of the instruction in D
// ctrl_d         in   CTRLWIDTH    control bundle for the instruction
// reg_write_d    in   1            instruction writes rd
// mem_read_d     in   1            instruction is a load
// pc_as_r1_d     in   1            reg1 operand is pc_d instead of R[rs1]
// imm_signed_d   in   1            1 = sign-extend imm, 0 = zero-extend
// wb_enable      in   1            writeback writes the register file
// wb_address     in   ADDRESSWIDTH writeback register
// wb_data        in   WIDTH        writeback value
// reg_write_m    in   1            M-stage instruction writes rd_m
// rd_m           in   ADDRESSWIDTH M-stage destination
// flush_e        in   1            taken branch/jump, kill the instruction entering E
// opcode_d       out  OPCODEWIDTH  opcode field, combinational
// stall_d        out  1            hold PC and the F/D register this cycle
// valid_e, reg_write_e, mem_read_e, pc_as_r1_e  out 1   registered flags
// ctrl_e         out  CTRLWIDTH    registered control bundle
// rd_e, rs1_e, rs2_e  out ADDRESSWIDTH  registered register addresses
// reg1_e, reg2_e, imm_e, pc_e  out WIDTH  registered operands, extended immediate and PC
// fwd_sel1_e, fwd_sel2_e  out 2   00 = register value, 01 = from M, 10 = from WB
// BEHAVIOUR
// - Reset (reset=0, async): all registers cleared to 0 and every *_e output 0. Effect is immediate,
//   mid-cycle included. stall_d=0 while in reset.
// - Register file: write on rising clock when wb_enable. Combinational read. If wb_enable and
//   wb_address==rs, the read returns wb_data (write-through). R0 is an ordinary register.
// - reg1 mux: pc_as_r1_d ? pc_d : R[rs1]. imm is IMMWIDTH wide and is extended to WIDTH per imm_signed_d.
// - Load-use hazard: hz = valid_e & mem_read_e & reg_write_e & instr_valid_d & (rd_e==rs1 | rd_e==rs2).
//   The rs1 compare is ignored when pc_as_r1_d=1.
// - stall_d = hz & ~flush_e.
// - D/E register, each rising edge, in priority order:
//   1. flush_e -> bubble
//   2. hz -> bubble
//   3. otherwise load D values, with valid_e = instr_valid_d.
// - Bubble: valid_e=reg_write_e=mem_read_e=0. Data fields hold their previous value (don't-care).
// - Latency: one cycle D->E. A stalled instruction enters E the cycle after the load leaves E.
// - Forwarding selects are combinational on E registers; they are 00 if ~valid_e. fwd_sel1_e is also 00 if pc_as_r1_e.
//   Per operand: 01 if reg_write_m & rd_m==rs_e, else 10 if wb_enable & wb_address==rs_e, else 00.
//   M takes priority over WB when both match.
// - Flush and stall together: the flush wins, no stall is issued, the D instruction is dropped by fetch.
// TESTING
// - Reset mid-run (reset=0 with valid_e=1) -> all *_e go to 0 at once; after release R[5] reads 0.
// - wb_enable=1, wb_address=3, wb_data=16'hBEEF, decode rs1=3 the same cycle -> reg1_e=16'hBEEF next edge.
// - Load rd=4 in E, D instruction rs2=4 -> stall_d=1 for one cycle, then a bubble (valid_e=0).
//   The instruction then enters E with fwd_sel2_e=10 once the load is in WB.
// - Same load-use case with flush_e=1 -> stall_d=0, valid_e=0 next edge.
// - rd_m=2 & reg_write_m, wb_address=2 & wb_enable, rs1_e=2 -> fwd_sel1_e=01. With pc_as_r1_e=1 -> 00.
// - imm=8'h80: imm_signed_d=1 -> imm_e=16'hFF80. imm_signed_d=0 -> imm_e=16'h0080.

Source files
------------

// File: rtl/decode_stage_hazard_if.sv
// decode_stage_hazard_if: decode-stage bus (D inputs, M/WB hazard info, E-stage outputs).
interface decode_stage_hazard_if #(
  parameter int WIDTH            = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int CTRLWIDTH        = 8
);
  logic                        instr_valid_d;
  logic [INSTRUCTIONWIDTH-1:0] instruction_d;
  logic [WIDTH-1:0]            pc_d;
  logic [CTRLWIDTH-1:0]        ctrl_d;
  logic                        reg_write_d;
  logic                        mem_read_d;
  logic                        pc_as_r1_d;
  logic                        imm_signed_d;
  logic                        wb_enable;
  logic [ADDRESSWIDTH-1:0]     wb_address;
  logic [WIDTH-1:0]            wb_data;
  logic                        reg_write_m;
  logic [ADDRESSWIDTH-1:0]     rd_m;
  logic                        flush_e;
  logic [OPCODEWIDTH-1:0]      opcode_d;
  logic                        stall_d;
  logic                        valid_e;
  logic                        reg_write_e;
  logic                        mem_read_e;
  logic                        pc_as_r1_e;
  logic [CTRLWIDTH-1:0]        ctrl_e;
  logic [ADDRESSWIDTH-1:0]     rd_e;
  logic [ADDRESSWIDTH-1:0]     rs1_e;
  logic [ADDRESSWIDTH-1:0]     rs2_e;
  logic [WIDTH-1:0]            reg1_e;
  logic [WIDTH-1:0]            reg2_e;
  logic [WIDTH-1:0]            imm_e;
  logic [WIDTH-1:0]            pc_e;
  logic [1:0]                  fwd_sel1_e;
  logic [1:0]                  fwd_sel2_e;
  modport master (
    output instr_valid_d, instruction_d, pc_d, ctrl_d, reg_write_d, mem_read_d, pc_as_r1_d,
           imm_signed_d, wb_enable, wb_address, wb_data, reg_write_m, rd_m, flush_e,
    input  opcode_d, stall_d, valid_e, reg_write_e, mem_read_e, pc_as_r1_e, ctrl_e, rd_e,
           rs1_e, rs2_e, reg1_e, reg2_e, imm_e, pc_e, fwd_sel1_e, fwd_sel2_e
  );
  modport slave (
    input  instr_valid_d, instruction_d, pc_d, ctrl_d, reg_write_d, mem_read_d, pc_as_r1_d,
           imm_signed_d, wb_enable, wb_address, wb_data, reg_write_m, rd_m, flush_e,
    output opcode_d, stall_d, valid_e, reg_write_e, mem_read_e, pc_as_r1_e, ctrl_e, rd_e,
           rs1_e, rs2_e, reg1_e, reg2_e, imm_e, pc_e, fwd_sel1_e, fwd_sel2_e
  );
endinterface

// File: rtl/decode_stage_hazard.sv
// decode_stage_hazard: register file, field split, D/E register with load-use stall, flush and forwarding selects.
module decode_stage_hazard #(
  parameter int WIDTH            = 16,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int IMMWIDTH         = 8,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int CTRLWIDTH        = 8
) (
  input logic                  clock,
  input logic                  reset,
  decode_stage_hazard_if.slave bus
);
  typedef struct packed {
    logic                    valid;
    logic                    reg_write;
    logic                    mem_read;
    logic                    pc_as_r1;
    logic [CTRLWIDTH-1:0]    ctrl;
    logic [ADDRESSWIDTH-1:0] rd;
    logic [ADDRESSWIDTH-1:0] rs1;
    logic [ADDRESSWIDTH-1:0] rs2;
    logic [WIDTH-1:0]        reg1;
    logic [WIDTH-1:0]        reg2;
    logic [WIDTH-1:0]        imm;
    logic [WIDTH-1:0]        pc;
  } de_t;
  de_t de_q, de_d;
  logic [WIDTH-1:0] rf_q [REGNUM];
  logic [WIDTH-1:0] rf_d [REGNUM];
  logic [ADDRESSWIDTH-1:0] rd, rs1, rs2;
  logic [IMMWIDTH-1:0] imm;
  logic [WIDTH-1:0] imm_x, rd1, rd2;
  logic hz;
  assign {bus.opcode_d, rd, rs1, rs2, imm} = bus.instruction_d;
  // write-through: a same-cycle writeback is visible to the decode read
  assign rd1 = (bus.wb_enable && bus.wb_address == rs1) ? bus.wb_data : rf_q[rs1];
  assign rd2 = (bus.wb_enable && bus.wb_address == rs2) ? bus.wb_data : rf_q[rs2];
  assign imm_x = bus.imm_signed_d ? WIDTH'($signed(imm)) : WIDTH'(imm);
  assign hz = de_q.valid & de_q.mem_read & de_q.reg_write & bus.instr_valid_d &
              ((~bus.pc_as_r1_d & (de_q.rd == rs1)) | (de_q.rd == rs2));
  assign bus.stall_d = hz & ~bus.flush_e;
  function automatic logic [1:0] fsel(input logic [ADDRESSWIDTH-1:0] rs, input logic en);
    return !en ? 2'b00 :
           (bus.reg_write_m && bus.rd_m == rs) ? 2'b01 :
           (bus.wb_enable && bus.wb_address == rs) ? 2'b10 : 2'b00;
  endfunction
  assign bus.fwd_sel1_e = fsel(de_q.rs1, de_q.valid & ~de_q.pc_as_r1);
  assign bus.fwd_sel2_e = fsel(de_q.rs2, de_q.valid);
  always_comb begin
    rf_d = rf_q;
    if (bus.wb_enable) rf_d[bus.wb_address] = bus.wb_data;
  end
  always_comb begin
    de_d = de_q;
    if (bus.flush_e | hz) begin
      de_d.valid     = 1'b0;
      de_d.reg_write = 1'b0;
      de_d.mem_read  = 1'b0;
    end else begin
      de_d = '{valid: bus.instr_valid_d, reg_write: bus.reg_write_d, mem_read: bus.mem_read_d,
               pc_as_r1: bus.pc_as_r1_d, ctrl: bus.ctrl_d, rd: rd, rs1: rs1, rs2: rs2,
               reg1: bus.pc_as_r1_d ? bus.pc_d : rd1, reg2: rd2, imm: imm_x, pc: bus.pc_d};
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      de_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      de_q <= de_d;
      rf_q <= rf_d;
    end
  end
  assign bus.valid_e     = de_q.valid;
  assign bus.reg_write_e = de_q.reg_write;
  assign bus.mem_read_e  = de_q.mem_read;
  assign bus.pc_as_r1_e  = de_q.pc_as_r1;
  assign bus.ctrl_e      = de_q.ctrl;
  assign bus.rd_e        = de_q.rd;
  assign bus.rs1_e       = de_q.rs1;
  assign bus.rs2_e       = de_q.rs2;
  assign bus.reg1_e      = de_q.reg1;
  assign bus.reg2_e      = de_q.reg2;
  assign bus.imm_e       = de_q.imm;
  assign bus.pc_e        = de_q.pc;
endmodule

// File: tb/tb_decode_stage_hazard.sv
// tb_decode_stage_hazard: random and directed stimulus checked against a behavioural decode/hazard model.
module tb_decode_stage_hazard;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  decode_stage_hazard_if bus();
  decode_stage_hazard dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  logic [15:0] m_rf [16];
  logic        e_valid, e_rw, e_mr, e_pa;
  logic [7:0]  e_ctrl;
  logic [3:0]  e_rd, e_rs1, e_rs2;
  logic [15:0] e_reg1, e_reg2, e_imm, e_pc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] rread(input logic [3:0] a);
    return (bus.wb_enable && bus.wb_address == a) ? bus.wb_data : m_rf[a];
  endfunction
  function automatic logic [15:0] ext(input logic [7:0] i, input logic s);
    int v = int'(i);
    if (s && v >= 128) v = v - 256;
    return 16'(v);
  endfunction
  function automatic logic [1:0] fsel(input logic [3:0] rs, input logic en);
    if (!en || !e_valid) return 2'd0;
    if (bus.reg_write_m && bus.rd_m == rs) return 2'd1;
    if (bus.wb_enable && bus.wb_address == rs) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic [23:0] ins(input logic [3:0] op, rd, r1, r2, input logic [7:0] im);
    return {op, rd, r1, r2, im};
  endfunction
  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    {e_valid, e_rw, e_mr, e_pa} = '0;
    {e_ctrl, e_rd, e_rs1, e_rs2} = '0;
    {e_reg1, e_reg2, e_imm, e_pc} = '0;
  endtask
  task automatic idle();
    bus.instr_valid_d = 0; bus.instruction_d = '0; bus.pc_d = '0; bus.ctrl_d = '0;
    bus.reg_write_d = 0; bus.mem_read_d = 0; bus.pc_as_r1_d = 0; bus.imm_signed_d = 0;
    bus.wb_enable = 0; bus.wb_address = '0; bus.wb_data = '0;
    bus.reg_write_m = 0; bus.rd_m = '0; bus.flush_e = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.valid_e, 0);
    chk({tag, "_rw"}, bus.reg_write_e, 0);
    chk({tag, "_mr"}, bus.mem_read_e, 0);
    chk({tag, "_pa"}, bus.pc_as_r1_e, 0);
    chk({tag, "_ctrl"}, bus.ctrl_e, 0);
    chk({tag, "_regs"}, {bus.rd_e, bus.rs1_e, bus.rs2_e}, 0);
    chk({tag, "_reg1"}, bus.reg1_e, 0);
    chk({tag, "_reg2"}, bus.reg2_e, 0);
    chk({tag, "_imm"}, bus.imm_e, 0);
    chk({tag, "_pc"}, bus.pc_e, 0);
    chk({tag, "_stall"}, bus.stall_d, 0);
  endtask
  task automatic rnd();
    bus.instr_valid_d = $urandom_range(0, 9) < 8;
    bus.instruction_d = ins(4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3)), 8'($urandom));
    bus.pc_d = 16'($urandom); bus.ctrl_d = 8'($urandom);
    bus.reg_write_d = 1'($urandom); bus.mem_read_d = 1'($urandom);
    bus.pc_as_r1_d = $urandom_range(0, 3) == 0; bus.imm_signed_d = 1'($urandom);
    bus.wb_enable = 1'($urandom); bus.wb_address = 4'($urandom_range(0, 3));
    bus.wb_data = 16'($urandom);
    bus.reg_write_m = 1'($urandom); bus.rd_m = 4'($urandom_range(0, 3));
    bus.flush_e = $urandom_range(0, 9) == 0;
  endtask
  // one clock: combinational checks, model step at the edge, registered checks
  task automatic cyc();
    logic [23:0] iw;
    logic hz;
    logic [15:0] r1, r2, im;
    #1;
    iw = bus.instruction_d;
    hz = e_valid && e_mr && e_rw && bus.instr_valid_d &&
         ((!bus.pc_as_r1_d && e_rd == iw[15:12]) || e_rd == iw[11:8]);
    chk("stall", bus.stall_d, hz && !bus.flush_e);
    chk("opcode", bus.opcode_d, iw[23:20]);
    chk("fwd1", bus.fwd_sel1_e, fsel(e_rs1, !e_pa));
    chk("fwd2", bus.fwd_sel2_e, fsel(e_rs2, 1'b1));
    r1 = bus.pc_as_r1_d ? bus.pc_d : rread(iw[15:12]);
    r2 = rread(iw[11:8]);
    im = ext(iw[7:0], bus.imm_signed_d);
    @(posedge clock);
    if (bus.wb_enable) m_rf[bus.wb_address] = bus.wb_data;
    if (bus.flush_e || hz) begin
      {e_valid, e_rw, e_mr} = '0;
    end else begin
      e_valid = bus.instr_valid_d; e_rw = bus.reg_write_d; e_mr = bus.mem_read_d;
      e_pa = bus.pc_as_r1_d; e_ctrl = bus.ctrl_d; e_rd = iw[19:16];
      e_rs1 = iw[15:12]; e_rs2 = iw[11:8]; e_reg1 = r1; e_reg2 = r2; e_imm = im; e_pc = bus.pc_d;
    end
    #1;
    chk("valid_e", bus.valid_e, e_valid);
    chk("reg_write_e", bus.reg_write_e, e_rw);
    chk("mem_read_e", bus.mem_read_e, e_mr);
    if (e_valid) begin
      chk("pc_as_r1_e", bus.pc_as_r1_e, e_pa);
      chk("ctrl_e", bus.ctrl_e, e_ctrl);
      chk("addr_e", {bus.rd_e, bus.rs1_e, bus.rs2_e}, {e_rd, e_rs1, e_rs2});
      chk("reg1_e", bus.reg1_e, e_reg1);
      chk("reg2_e", bus.reg2_e, e_reg2);
      chk("imm_e", bus.imm_e, e_imm);
      chk("pc_e", bus.pc_e, e_pc);
    end
    @(negedge clock);
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b1;
    repeat (400) begin
      rnd();
      cyc();
    end
    idle(); cyc();
    bus.instr_valid_d = 1; bus.instruction_d = ins(1, 7, 3, 0, 0);
    bus.wb_enable = 1; bus.wb_address = 3; bus.wb_data = 16'hBEEF;
    cyc();
    chk("bypass", bus.reg1_e, 16'hBEEF);
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(2, 1, 0, 0, 8'h80);
    bus.imm_signed_d = 1; cyc();
    chk("imm_sext", bus.imm_e, 16'hFF80);
    bus.imm_signed_d = 0; cyc();
    chk("imm_zext", bus.imm_e, 16'h0080);
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(3, 4, 0, 0, 0);
    bus.reg_write_d = 1; bus.mem_read_d = 1; cyc();
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(4, 5, 1, 4, 0); bus.reg_write_d = 1;
    #1 chk("lu_stall", bus.stall_d, 1);
    cyc();
    chk("lu_bubble", bus.valid_e, 0);
    bus.reg_write_m = 1; bus.rd_m = 4;
    #1 chk("lu_release", bus.stall_d, 0);
    cyc();
    chk("lu_enter", bus.valid_e, 1);
    bus.reg_write_m = 0; bus.instr_valid_d = 0;
    bus.wb_enable = 1; bus.wb_address = 4; bus.wb_data = 16'h1234;
    #1 chk("lu_fwd2", bus.fwd_sel2_e, 2'b10);
    cyc();
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(3, 4, 0, 0, 0);
    bus.reg_write_d = 1; bus.mem_read_d = 1; cyc();
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(4, 5, 1, 4, 0); bus.flush_e = 1;
    #1 chk("flush_stall", bus.stall_d, 0);
    cyc();
    chk("flush_bubble", bus.valid_e, 0);
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(5, 6, 2, 0, 0); cyc();
    bus.reg_write_m = 1; bus.rd_m = 2; bus.wb_enable = 1; bus.wb_address = 2; bus.wb_data = 16'd7;
    bus.pc_as_r1_d = 1;
    #1 chk("fwd_m_prio", bus.fwd_sel1_e, 2'b01);
    cyc();
    #1 chk("fwd_pc_r1", bus.fwd_sel1_e, 2'b00);
    cyc();
    idle(); bus.instr_valid_d = 1; bus.instruction_d = ins(6, 5, 0, 0, 0); bus.reg_write_d = 1;
    bus.wb_enable = 1; bus.wb_address = 5; bus.wb_data = 16'h5555;
    cyc();
    idle();
    #2 reset = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.instr_valid_d = 1; bus.instruction_d = ins(7, 1, 5, 0, 0);
    cyc();
    chk("r5_cleared", bus.reg1_e, 16'h0000);
    repeat (100) begin
      rnd();
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
